// File: rtl/bsg_mcl_word_serdes_pkg.sv
// rtl/bsg_mcl_word_serdes_pkg.sv - shared constants and types for the MCL word serdes
package bsg_mcl_word_serdes_pkg;

    localparam int words_per_pkt_lp = 4;

    typedef logic [1:0] word_idx_t;

    localparam word_idx_t last_word_idx_lp = word_idx_t'(words_per_pkt_lp - 1);

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small register-based FIFO with valid/ready in, valid/yumi out
module bsg_fifo_1r1w_small #(
    parameter int width_p = 128,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;

    // Callers only raise v_i when ready_o is high and yumi_i when v_o is high.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (v_i) begin
            wptr_d  = (wptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wptr_q + ptr_w_lp'(1);
            count_d = count_d + cnt_w_lp'(1);
        end
        if (yumi_i) begin
            rptr_d  = (rptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rptr_q + ptr_w_lp'(1);
            count_d = count_d - cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign ready_o = (count_q != cnt_w_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];

endmodule

// File: rtl/bsg_mcl_word_serdes.sv
// rtl/bsg_mcl_word_serdes.sv - host word to MCL packet serializer/deserializer
module bsg_mcl_word_serdes
    import bsg_mcl_word_serdes_pkg::*;
#(
    parameter int word_width_p   = 32,
    parameter int packet_width_p = 4 * word_width_p,
    parameter int rx_els_p       = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               tx_word_v_i,
    input  logic [word_width_p-1:0]            tx_word_i,
    output logic                               tx_word_ready_o,
    output logic                               pkt_v_o,
    output logic [packet_width_p-1:0]          pkt_data_o,
    input  logic                               pkt_ready_i,
    input  logic                               pkt_v_i,
    input  logic [packet_width_p-1:0]          pkt_data_i,
    output logic                               pkt_ready_o,
    output logic                               rx_word_v_o,
    output logic [word_width_p-1:0]            rx_word_o,
    input  logic                               rx_word_yumi_i,
    output logic [$clog2(4*rx_els_p+1)-1:0]    rx_occupancy_o
);

    localparam int occ_w_lp = $clog2(4 * rx_els_p + 1);

    // Held low through reset so both ready outputs stay deasserted until release.
    logic running_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) running_q <= 1'b0;
        else            running_q <= 1'b1;
    end

    logic                      tx_accept;
    word_idx_t                 tx_idx_q, tx_idx_d;
    logic [packet_width_p-1:0] tx_data_q, tx_data_d;
    logic                      pkt_v_q, pkt_v_d;

    assign tx_word_ready_o = running_q & ~pkt_v_q;
    assign tx_accept       = tx_word_v_i & tx_word_ready_o;

    always_comb begin
        tx_idx_d  = tx_idx_q;
        tx_data_d = tx_data_q;
        pkt_v_d   = pkt_v_q;
        if (pkt_v_q && pkt_ready_i) begin
            pkt_v_d = 1'b0;
        end
        if (tx_accept) begin
            tx_data_d[int'(tx_idx_q)*word_width_p +: word_width_p] = tx_word_i;
            tx_idx_d = tx_idx_q + word_idx_t'(1);
            if (tx_idx_q == last_word_idx_lp) begin
                pkt_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            tx_idx_q  <= '0;
            tx_data_q <= '0;
            pkt_v_q   <= 1'b0;
        end else begin
            tx_idx_q  <= tx_idx_d;
            tx_data_q <= tx_data_d;
            pkt_v_q   <= pkt_v_d;
        end
    end

    assign pkt_v_o    = pkt_v_q;
    assign pkt_data_o = tx_data_q;

    logic                      fifo_ready;
    logic                      fifo_v;
    logic [packet_width_p-1:0] fifo_data;
    logic                      rx_enq;
    logic                      rx_yumi;
    logic                      rx_deq;
    word_idx_t                 rx_idx_q, rx_idx_d;
    logic [occ_w_lp-1:0]       occ_q, occ_d;

    assign pkt_ready_o = running_q & fifo_ready;
    assign rx_enq      = pkt_v_i & pkt_ready_o;
    assign rx_yumi     = rx_word_yumi_i & rx_word_v_o;
    assign rx_deq      = rx_yumi & (rx_idx_q == last_word_idx_lp);

    bsg_fifo_1r1w_small #(
        .width_p (packet_width_p),
        .els_p   (rx_els_p)
    ) rx_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (rx_enq),
        .data_i    (pkt_data_i),
        .ready_o   (fifo_ready),
        .v_o       (fifo_v),
        .data_o    (fifo_data),
        .yumi_i    (rx_deq)
    );

    // Occupancy is tracked directly rather than derived from the FIFO count so
    // that it is a clean register: +4 per enqueue, -1 per consumed word.
    always_comb begin
        rx_idx_d = rx_idx_q;
        occ_d    = occ_q;
        if (rx_enq) begin
            occ_d = occ_d + occ_w_lp'(words_per_pkt_lp);
        end
        if (rx_yumi) begin
            rx_idx_d = rx_idx_q + word_idx_t'(1);
            occ_d    = occ_d - occ_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rx_idx_q <= '0;
            occ_q    <= '0;
        end else begin
            rx_idx_q <= rx_idx_d;
            occ_q    <= occ_d;
        end
    end

    assign rx_word_v_o    = fifo_v;
    assign rx_word_o      = fifo_data[int'(rx_idx_q)*word_width_p +: word_width_p];
    assign rx_occupancy_o = occ_q;

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(rx_word_yumi_i && !rx_word_v_o))
                else $error("rx_word_yumi_i asserted while rx_word_v_o is low");
        end
    end

endmodule
